alu_cmd_sequencer: RTL

Command-side driver for `param_alu`. It accepts operand/opcode commands through a valid/ready FIFO and issues them one at a time to the combinational ALU through registered inputs. It captures the ALU result and flags, then returns them on a valid/ready response port. It sits between any command source (CPU datapath, test sequencer) and a `param_alu` instance, replacing ad-hoc stimulus driving.

---
 rtl/alu_cmd_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for param_alu: FIFO-buffered commands, registered ALU drive,
// captured result/flags on a valid/ready response port. Optional: ALU_SEQ_ERR_CNT_EN.
module alu_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [3:0]       cmd_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_s,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_zero,
    input  logic             alu_negative,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_c,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [7:0]       err_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Legal opcodes: 0000-0101 and 1000-1011.
    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        case (op[3:2])
            2'b00:   legal = 1'b1;
            2'b01:   legal = (op[1] == 1'b0);
            2'b10:   legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    logic [WIDTH-1:0] mem_a_r  [DEPTH];
    logic [WIDTH-1:0] mem_b_r  [DEPTH];
    logic [3:0]       mem_op_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [AW:0]      count_r, count_next_s;
    logic             cmd_ready_r;

    state_t           state_r, state_next_s;
    logic             push_s, pop_s, issue_s, err_load_s, capture_s;
    logic             empty_s, head_legal_s;

    logic [WIDTH-1:0] alu_a_r, alu_b_r, rsp_c_r;
    logic [3:0]       alu_s_r, rsp_flags_r;
    logic             rsp_valid_r, rsp_err_r;

    assign push_s       = cmd_valid && cmd_ready_r;
    assign empty_s      = (count_r == {(AW+1){1'b0}});
    assign head_legal_s = op_is_legal(mem_op_r[rd_ptr_r]);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + ONE_CNT;
            2'b01:   count_next_s = count_r - ONE_CNT;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO pointers, occupancy and ready flag (ready reflects occupancy only, no pop lookahead).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {(AW+1){1'b0}};
            cmd_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            count_r     <= count_next_s;
            cmd_ready_r <= (count_next_s < FULL_CNT);
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_a_r[wr_ptr_r]  <= cmd_a;
            mem_b_r[wr_ptr_r]  <= cmd_b;
            mem_op_r[wr_ptr_r] <= cmd_op;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: RESP handshake reuses the IDLE pop rules for back-to-back issue.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_next_s = head_legal_s ? ST_EXEC : ST_RESP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: state_next_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready && !empty_s) begin
                    state_next_s = head_legal_s ? ST_EXEC : ST_RESP;
                end else if (rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: pop/issue/error-load/capture strobes.
    always_comb begin
        pop_s      = 1'b0;
        capture_s  = 1'b0;
        case (state_r)
            ST_IDLE: pop_s = !empty_s;
            ST_EXEC: capture_s = 1'b1;
            ST_RESP: pop_s = rsp_ready && !empty_s;
            default: pop_s = 1'b0;
        endcase
        if (pop_s) begin
            issue_s    = head_legal_s;
            err_load_s = !head_legal_s;
        end else begin
            issue_s    = 1'b0;
            err_load_s = 1'b0;
        end
    end

    // ALU drive and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_r     <= {WIDTH{1'b0}};
            alu_b_r     <= {WIDTH{1'b0}};
            alu_s_r     <= 4'b0000;
            rsp_valid_r <= 1'b0;
            rsp_c_r     <= {WIDTH{1'b0}};
            rsp_flags_r <= 4'b0000;
            rsp_err_r   <= 1'b0;
        end else begin
            if (issue_s) begin
                alu_a_r <= mem_a_r[rd_ptr_r];
                alu_b_r <= mem_b_r[rd_ptr_r];
                alu_s_r <= mem_op_r[rd_ptr_r];
            end
            rsp_valid_r <= (state_next_s == ST_RESP);
            if (err_load_s) begin
                rsp_c_r     <= {WIDTH{1'b0}};
                rsp_flags_r <= 4'b0000;
                rsp_err_r   <= 1'b1;
            end else if (capture_s) begin
                rsp_c_r     <= alu_c;
                rsp_flags_r <= {alu_zero, alu_negative, alu_carry, alu_overflow};
                rsp_err_r   <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_ERR_CNT_EN
    logic [7:0] err_count_r;

    // Saturating illegal-opcode counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_r <= 8'd0;
        end else if (err_load_s && (err_count_r != 8'hFF)) begin
            err_count_r <= err_count_r + 8'd1;
        end
    end

    assign err_count = err_count_r;
`else
    assign err_count = 8'd0;
`endif

    assign cmd_ready = cmd_ready_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_s     = alu_s_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_c     = rsp_c_r;
    assign rsp_flags = rsp_flags_r;
    assign rsp_err   = rsp_err_r;

endmodule
